// File: rtl/avalon_burst_mem_pkg.sv
// avalon_burst_mem_pkg: shared FSM states, address constants and width helpers.
package avalon_burst_mem_pkg;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_e;
  localparam int AV_AW = 64;
  function automatic int word_aw(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/avalon_burst_mem_be_sram.sv
// be_sram: single-port byte-enabled RAM with registered, write-first read.
module be_sram
  import avalon_burst_mem_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 512,
  parameter int INIT_ZERO = 1
) (
  input  logic                        clk,
  input  logic                        wr_i,
  input  logic [word_aw(DEPTH)-1:0]   Addr_i,
  input  logic [be_w(DATA_W)-1:0]     ByteEnable_i,
  input  logic [DATA_W-1:0]           WriteData_i,
  output logic [DATA_W-1:0]           ReadData_o
);
  localparam int BW = be_w(DATA_W);
  localparam logic [DATA_W-1:0] INIT_V = (INIT_ZERO != 0) ? '0 : 'x;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_V};
  logic [DATA_W-1:0] merged;
  always_comb begin
    merged = mem[Addr_i];
    for (int b = 0; b < BW; b++)
      if (ByteEnable_i[b]) merged[b*8+:8] = WriteData_i[b*8+:8];
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < BW; b++)
      if (wr_i && ByteEnable_i[b]) mem[Addr_i][b*8+:8] <= WriteData_i[b*8+:8];
    ReadData_o <= wr_i ? merged : mem[Addr_i];
  end
endmodule

// File: rtl/avalon_burst_mem.sv
// avalon_burst_mem: Avalon-MM pipelined-burst slave in front of a byte-enabled block RAM.
module avalon_burst_mem
  import avalon_burst_mem_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 512,
  parameter int BURST_W   = 4,
  parameter int INIT_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [AV_AW-1:0]        AvalonAddr_i,
  input  logic [BURST_W-1:0]      AvalonBurstCount_i,
  input  logic                    AvalonRead_i,
  input  logic                    AvalonWrite_i,
  input  logic [be_w(DATA_W)-1:0] AvalonByteEnable_i,
  input  logic [DATA_W-1:0]       AvalonWriteData_i,
  output logic [DATA_W-1:0]       AvalonReadData_o,
  output logic                    AvalonReadDataValid_o,
  output logic                    AvalonWaitReq_o
);
  localparam int AW  = word_aw(DEPTH);
  localparam int LSB = $clog2(be_w(DATA_W));
  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d, ram_addr, word;
  logic [BURST_W-1:0]  cnt_q, cnt_d, bc;
  logic                pend_q, pend_d, valid_q, ram_wr, unused_addr;
  logic [DATA_W-1:0]   data_q, ram_q;
  assign word        = AvalonAddr_i[AW+LSB-1:LSB];
  assign unused_addr = ^AvalonAddr_i;
  assign bc          = (AvalonBurstCount_i == '0) ? BURST_W'(1) : AvalonBurstCount_i;
  // pend_q marks a RAM read issued last cycle whose data lands in ram_q now
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    pend_d   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = addr_q;
    case (state_q)
      IDLE: begin
        ram_addr = word;
        if (AvalonWrite_i) begin
          ram_wr = 1'b1;
          if (bc > BURST_W'(1)) begin
            cnt_d   = bc - 1'b1;
            addr_d  = word + 1'b1;
            state_d = WR_BURST;
          end
        end else if (AvalonRead_i) begin
          cnt_d   = bc;
          addr_d  = word;
          state_d = RD_BURST;
        end
      end
      WR_BURST: if (AvalonWrite_i) begin
        ram_wr  = 1'b1;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == BURST_W'(1)) ? IDLE : WR_BURST;
      end
      RD_BURST: begin
        pend_d = cnt_q != '0;
        if (cnt_q != '0) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end else if (!pend_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= pend_q;
      data_q  <= pend_q ? ram_q : data_q;
    end
  end
  be_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_ZERO(INIT_ZERO)) u_ram (
    .clk          (clk),
    .wr_i         (ram_wr),
    .Addr_i       (ram_addr),
    .ByteEnable_i (AvalonByteEnable_i),
    .WriteData_i  (AvalonWriteData_i),
    .ReadData_o   (ram_q)
  );
  assign AvalonReadData_o      = data_q;
  assign AvalonReadDataValid_o = valid_q;
  assign AvalonWaitReq_o       = state_q == RD_BURST;
endmodule

// File: tb/tb_avalon_burst_mem.sv
// tb_avalon_burst_mem: randomized bursts checked against an array model of the memory.
module tb_avalon_burst_mem;
  localparam int DW = 512, DP = 512, BUW = 4, BEW = DW / 8;
  logic            clk = 1'b0, rstn = 1'b0;
  logic [63:0]     addr;
  logic [BUW-1:0]  bc;
  logic            rd, wr, rvalid, wait_o;
  logic [BEW-1:0]  be;
  logic [DW-1:0]   wdata, rdata;
  logic [DW-1:0]   mem_m [DP];
  logic [DW-1:0]   wq [$];
  int n_chk = 0, n_fail = 0;
  avalon_burst_mem #(.DATA_W(DW), .DEPTH(DP), .BURST_W(BUW), .INIT_ZERO(1)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .AvalonAddr_i          (addr),
    .AvalonBurstCount_i    (bc),
    .AvalonRead_i          (rd),
    .AvalonWrite_i         (wr),
    .AvalonByteEnable_i    (be),
    .AvalonWriteData_i     (wdata),
    .AvalonReadData_o      (rdata),
    .AvalonReadDataValid_o (rvalid),
    .AvalonWaitReq_o       (wait_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction
  function automatic logic [63:0] mk_addr(input int w);
    logic [63:0] a = {32'($urandom()), 32'($urandom())};
    a[14:6] = 9'(w);
    return a;
  endfunction
  task automatic write_burst(input int w, input int bcf, input logic [BEW-1:0] b,
                             input int bub_at, input int bub_len, input bit both);
    int n = (bcf == 0) ? 1 : bcf;
    for (int i = 0; i < n; i++) begin
      if (i == bub_at) repeat (bub_len) begin
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
      end
      @(negedge clk);
      chk("wr_wait", DW'(wait_o), '0);
      wr    = 1'b1;
      rd    = both && i == 0;
      addr  = (i == 0) ? mk_addr(w) : {32'($urandom()), 32'($urandom())};
      bc    = (i == 0) ? BUW'(bcf) : BUW'($urandom_range(0, 15));
      be    = b;
      wdata = wq[i];
      for (int k = 0; k < BEW; k++)
        if (b[k]) mem_m[(w + i) % DP][k*8+:8] = wq[i][k*8+:8];
      @(posedge clk);
    end
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    if (both) for (int k = 0; k < 4; k++) begin
      chk("rw_no_valid", DW'(rvalid), '0);
      chk("rw_no_wait", DW'(wait_o), '0);
      @(negedge clk);
    end
  endtask
  task automatic read_burst(input int w, input int bcf, input int rst_at);
    int n = (bcf == 0) ? 1 : bcf;
    int seen = 0, g = 0;
    @(negedge clk);
    while (wait_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("rd_ready", DW'(wait_o), '0);
    rd   = 1'b1;
    wr   = 1'b0;
    addr = mk_addr(w);
    bc   = BUW'(bcf);
    @(posedge clk);
    @(negedge clk);
    rd   = 1'b0;
    addr = {32'($urandom()), 32'($urandom())};
    chk("rd_wait_T", DW'(wait_o), DW'(1));
    chk("rd_valid_T", DW'(rvalid), '0);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      chk("rd_valid", DW'(rvalid), DW'(k >= 2 && k <= n + 1));
      chk("rd_wait", DW'(wait_o), DW'(k <= n + 1));
      if (k >= 2 && k <= n + 1) begin
        chk("rd_data", rdata, mem_m[(w + k - 2) % DP]);
        seen++;
      end else if (k == n + 2) chk("rd_hold", rdata, mem_m[(w + n - 1) % DP]);
      if (seen == rst_at) begin
        rstn = 1'b0;
        #1;
        chk("rst_valid", DW'(rvalid), '0);
        chk("rst_wait", DW'(wait_o), '0);
        chk("rst_data", rdata, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) begin
          @(negedge clk);
          chk("rst_no_valid", DW'(rvalid), '0);
          chk("rst_idle", DW'(wait_o), '0);
        end
        return;
      end
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, bcf;
    wr = 1'b0; rd = 1'b0; addr = '0; bc = '0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wait", DW'(wait_o), '0);
    chk("reset_valid", DW'(rvalid), '0);
    chk("reset_data", rdata, '0);
    rstn = 1'b1;
    for (int i = 0; i < DP; i += 8) begin
      wq.delete();
      repeat (8) wq.push_back(rnd_word());
      write_burst(i, 8, '1, -1, 0, 1'b0);
    end
    wq = '{{64{8'hA5}}};
    write_burst(1, 1, '1, -1, 0, 1'b0);
    read_burst(1, 1, -1);
    wq = '{{DW{1'b1}}};
    write_burst(3, 1, '1, -1, 0, 1'b0);
    wq = '{'0};
    write_burst(3, 1, BEW'(1), -1, 0, 1'b0);
    read_burst(3, 1, -1);
    chk("be_merge", rdata, {{(BEW-1){8'hFF}}, 8'h00});
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(DW'(i));
    write_burst(508, 8, '1, -1, 0, 1'b0);
    read_burst(508, 8, -1);
    read_burst(0, 4, -1);
    chk("wrap_word3", rdata, DW'(7));
    wq.delete();
    repeat (4) wq.push_back(rnd_word());
    write_burst(20, 4, '1, 2, 2, 1'b0);
    read_burst(20, 5, -1);
    read_burst(5, 0, -1);
    wq = '{rnd_word()};
    write_burst(6, 0, '1, -1, 0, 1'b0);
    read_burst(6, 1, -1);
    wq = '{rnd_word()};
    write_burst(7, 1, '1, -1, 0, 1'b1);
    read_burst(7, 1, -1);
    read_burst(100, 8, 3);
    read_burst(100, 1, -1);
    repeat (40) begin
      w   = $urandom_range(0, DP - 1);
      bcf = $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        repeat ((bcf == 0) ? 1 : bcf) wq.push_back(rnd_word());
        write_burst(w, bcf, {32'($urandom()), 32'($urandom())},
                    $urandom_range(0, 8), $urandom_range(0, 2), 1'b0);
      end else read_burst(w, bcf, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/avalon_burst_mem.md
Name: avalon_burst_mem

Overview:
Parametrised Avalon-MM pipelined-burst slave with a byte-enabled single-port block-RAM behind it. It succeeds the fixed 512-bit, single-beat memory wrapper. Data width, depth and maximum burst length are parameters, and it adds read/write bursts with readdatavalid and address wrap-around. It sits on the HPS/FPGA fabric bridge as a scratch/weight buffer.

Parameters:
DATA_W, 512, data bus width in bits; multiple of 8, power of two.
DEPTH, 512, number of DATA_W words; power of two.
BURST_W, 4, burstcount width; maximum burst is 2^(BURST_W-1) beats.
INIT_ZERO, 1, 1 = RAM contents zero at configuration; 0 = undefined.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
AvalonAddr_i  in  64  byte address; word index = Addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; upper bits ignored
AvalonBurstCount_i  in  BURST_W  beats in burst; sampled with the command
AvalonRead_i  in  1  read command
AvalonWrite_i  in  1  write beat
AvalonByteEnable_i  in  DATA_W/8  per-byte write enable
AvalonWriteData_i  in  DATA_W  write data
AvalonReadData_o  out  DATA_W  read data (registered)
AvalonReadDataValid_o  out  1  one pulse per returned read beat
AvalonWaitReq_o  out  1  command/beat not accepted this cycle

Behaviour:
- Reset (async assert, sync deassert by the caller's reset tree) forces the following; RAM contents are untouched:
  - state=IDLE, AvalonWaitReq_o=0, AvalonReadDataValid_o=0, AvalonReadData_o=0.
  - Beat counter and address counter = 0.
- Acceptance rule: a command or beat is accepted on a rising edge where (Read|Write)=1 and AvalonWaitReq_o=0.
- Burstcount 0 is treated as 1. Read and write both high in IDLE: the write wins and the read is ignored, not queued.
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE:
  - AvalonWaitReq_o=0.
  - Write accepted: RAM written at that edge with the latched word index and ByteEnable. If burstcount>1, latch remaining=burstcount-1 and addr+1, then go to WR_BURST.
  - Read accepted: latch word index and count=burstcount, go to RD_BURST. AvalonWaitReq_o goes high from the next cycle.
- WR_BURST:
  - AvalonWaitReq_o=0. Each edge with Write=1 writes one beat at the internal address, which increments; the address bus is ignored.
  - Write=0 is a bubble and the counter holds. Read asserted here is held off only in the sense that it is not decoded; the master must not issue it mid-burst.
  - After the last beat, go to IDLE.
- RD_BURST:
  - AvalonWaitReq_o=1. One RAM read is issued per cycle for count cycles, with the address incrementing each cycle.
  - RAM has one-cycle registered output. Data passes through the output register, so the first beat has AvalonReadDataValid_o=1 in cycle T+2, where T is the acceptance edge.
  - Beats are contiguous with no bubbles. AvalonWaitReq_o falls in the cycle after the last valid beat, and the state returns to IDLE on that edge.
  - Back-to-back read: the next command is accepted no earlier than the cycle after the final readdatavalid.
- Address wrap: the internal word address increments modulo DEPTH, so DEPTH-1 is followed by 0.
- ByteEnable all-zero: the beat is accepted and counted, but no byte changes.
- AvalonReadData_o holds its last value when readdatavalid=0.
- Reset mid-burst:
  - Return to IDLE immediately and drop pending read beats with no further readdatavalid.
  - Write beats already written remain in RAM.

Decomposition:
- Shared package:
  - State enum (IDLE/WR_BURST/RD_BURST).
  - Functions clog2-based WORD_AW=log2(DEPTH) and BE_W=DATA_W/8.
  - Constant for the 64-bit Avalon address width.
- One sub-module, be_sram:
  - Single-port RAM with parameters DATA_W and DEPTH.
  - Ports clk, wr_i, Addr_i, ByteEnable_i, WriteData_i, ReadData_o.
  - Registered read, write-first on the same address.
- The FSM, counters and output register live in avalon_burst_mem.

Test Plan:
- Single write then single read: write Addr=0x40 (word 1), data=0xA5 pattern, BE=all 1s, burst=1.
  - Read word 1 -> readdatavalid pulses at T+2 with the pattern.
  - waitrequest is high for cycles T+1..T+2 and low at T+3.
- Byte-enable merge: write word 3 all-0xFF, then write 0x00 with BE=0x...0001.
  - Read -> byte0=0x00, all other bytes 0xFF.
- Write burst of 8 from word 508 (DEPTH=512), data=beat index.
  - Read burst of 8 from word 508 -> 8 contiguous valid beats, values 0..7.
  - Words 508..511 then 0..3 are written, proving wrap.
- Write burst with Write deasserted for 2 cycles after beat 2: no extra beats, counter holds, final contents match 4 beats.
- Burstcount=0 read at word 5: exactly one readdatavalid, then IDLE. Simultaneous Read&Write in IDLE: only the write is performed and there is no readdatavalid.
- Reset asserted after the 3rd readdatavalid of an 8-beat read:
  - Outputs return to 0 asynchronously and no further readdatavalid appears.
  - A new single read after reset returns correct data.
